// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} div_state_t;

  // Negates the low w bits of v when neg is set; the result is masked to w bits.
  function automatic logic [63:0] cond_negate(input logic [63:0] v, input logic neg,
                                              input int unsigned w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (neg ? (~v + 64'd1) : v) & mask;
  endfunction

endpackage

// File: rtl/seq_divider_step.sv
// One combinational restoring-division step on a {R,Q} pair with divisor D.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   R_i,
  input  logic [WIDTH-1:0] Q_i,
  input  logic [WIDTH-1:0] D_i,
  output logic [WIDTH:0]   R_next_o,
  output logic [WIDTH-1:0] Q_next_o
);

  logic [WIDTH:0]   rShifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  // A bit shifted out of R's top means the value already exceeds any divisor.
  always_comb begin
    rShifted = {R_i[WIDTH-1:0], Q_i[WIDTH-1]};
    trial    = {1'b0, rShifted} - {2'b00, D_i};
    fits     = R_i[WIDTH] | ~trial[WIDTH+1];
    R_next_o = fits ? trial[WIDTH:0] : rShifted;
    Q_next_o = {Q_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider with a level-sensitive Start handshake and optional signed mode.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter bit SIGNED = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             Busy,
  output logic             Done,
  output logic             Div_By_Zero,
  output logic             Overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST    = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [WIDTH-1:0] dvdRaw_q;
  logic [CW-1:0]    count_q;
  logic             negQ_q;
  logic             negR_q;
  logic             dbz_q;
  logic             ovf_q;
  logic             fixPhase_q;
  logic [WIDTH-1:0] qFix_q;
  logic [WIDTH-1:0] rFix_q;

  logic             dvdNeg;
  logic             dvsNeg;
  logic [WIDTH-1:0] dvdMag;
  logic [WIDTH-1:0] dvsMag;
  logic [WIDTH:0]   rStep;
  logic [WIDTH-1:0] qStep;

  assign dvdNeg = SIGNED && Dividend[WIDTH-1];
  assign dvsNeg = SIGNED && Divisor[WIDTH-1];
  assign dvdMag = WIDTH'(cond_negate(64'(Dividend), dvdNeg, WIDTH));
  assign dvsMag = WIDTH'(cond_negate(64'(Divisor), dvsNeg, WIDTH));

  div_step #(.WIDTH(WIDTH)) u_step (
    .R_i      (r_q),
    .Q_i      (q_q),
    .D_i      (d_q),
    .R_next_o (rStep),
    .Q_next_o (qStep)
  );

  // FIX spans two cycles: sign correction is registered first, then copied to
  // the outputs, so results only ever change on the FIX->DONE edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      dvdRaw_q    <= '0;
      count_q     <= '0;
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      fixPhase_q  <= 1'b0;
      qFix_q      <= '0;
      rFix_q      <= '0;
      Quotient    <= '0;
      Remainder   <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Div_By_Zero <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            q_q        <= dvdMag;
            d_q        <= dvsMag;
            dvdRaw_q   <= Dividend;
            r_q        <= '0;
            count_q    <= '0;
            negQ_q     <= dvdNeg ^ dvsNeg;
            negR_q     <= dvdNeg;
            dbz_q      <= (Divisor == '0);
            ovf_q      <= SIGNED && (Dividend == MIN_VAL) && (Divisor == '1);
            fixPhase_q <= 1'b0;
            Busy       <= 1'b1;
            state_q    <= ITER;
          end
        end
        ITER: begin
          r_q <= rStep;
          q_q <= qStep;
          if (count_q == LAST) begin
            state_q <= FIX;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        FIX: begin
          if (!fixPhase_q) begin
            qFix_q     <= dbz_q ? '1 :
                          WIDTH'(cond_negate(64'(q_q), negQ_q, WIDTH));
            rFix_q     <= dbz_q ? dvdRaw_q :
                          WIDTH'(cond_negate(64'(r_q[WIDTH-1:0]), negR_q, WIDTH));
            fixPhase_q <= 1'b1;
          end else begin
            Quotient    <= qFix_q;
            Remainder   <= rFix_q;
            Div_By_Zero <= dbz_q;
            Overflow    <= ovf_q;
            fixPhase_q  <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (!Start) begin
            Done    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assert property (@(posedge Clk) disable iff (!Reset_n) !(Busy && Done));
  assert property (@(posedge Clk) disable iff (!Reset_n) count_q <= LAST);

endmodule
